an_decoder_hl: RTL and testbench
================================

Name: an_decoder_hl

Overview:
- Pipelined decoder for an AN arithmetic code with A=29.
- Takes a 28-bit received word ANe = A*N that may carry one unidirectional high-to-low bit error (a single 1 flipped to 0).
- Corrects the error and returns the 23-bit data word N.
- Sits between protected storage or a datapath and consumers of plain binary data.

Parameters:
- A, 29, code constant. It must be odd and 2 must have multiplicative order >= CW_W mod A, so the -2^i residues are distinct.
- CW_W, 28, codeword width.
- N_W, 23, decoded data width.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  an_in is valid this cycle
- an_in  input  28  received codeword ANe
- out_valid  output  1  n_out and the status outputs are valid
- n_out  output  23  corrected data N
- err_det  output  1  nonzero residue was detected
- err_uncorr  output  1  the word could not be corrected; n_out is not trustworthy

Behaviour:
- Reset: asynchronous on rst_n low. All pipeline registers clear, so out_valid=0, n_out=0, err_det=0, err_uncorr=0. Reset asserted mid-operation drops all in-flight words. After release, the first output appears 2 cycles after the next in_valid.
- Fully pipelined, 2-cycle latency, one word per cycle. There is no backpressure, so out_valid is in_valid delayed by 2 cycles.
- Stage 1, registered:
  - Capture an_in.
  - Compute R = an_in mod A. Constant modulus, combinational reduction; no divider IP.
- Stage 2, registered:
  - R=0: C = an_in, err_det=0.
  - R!=0: look up the unique i in 0..CW_W-1 with (-2^i) mod A == R. For A=29 all 28 nonzero residues map one-to-one to bits 0..27, e.g. R=27->bit1, 21->3, 13->4, 26->5, 23->6, 17->7, 5->8, 10->9, 20->10, 1->14, 8->17, 3->19.
  - Set err_det=1.
  - If an_in[i]==0: C = an_in | (1<<i) (restores the dropped 1, no carry).
  - If an_in[i]==1: the error is not a single HL error. Set err_uncorr=1, C=an_in.
  - n_out = C / A. An exact-division implementation is allowed: (C * A^-1 mod 2^N_W) mod 2^N_W.
  - If C > A*(2^N_W - 1): set err_uncorr=1; n_out = low N_W bits of the quotient.
- Outputs hold their last values while out_valid=0.
- Status flags are only meaningful when out_valid=1.

Optional Feature:
- Macro: ANDEC_ERRPOS_EN.
- Defined:
  - Adds output port err_pos [4:0], the corrected bit index i, valid with out_valid. It is 0 when err_det=0.
  - Adds output port residue [4:0], the registered R.
  - Both reset to 0.
- Undefined: neither port exists. Core behaviour and latency are unchanged.

Test Plan:
- Clean word: an_in=673786 (29*23234) -> 2 cycles later out_valid=1, n_out=23234, err_det=0, err_uncorr=0.
- Low-bit sweep: back-to-back inputs 673784, 673778, 673770, 673754, 673722, 673658, 673530, 673274, 672762, one per cycle -> stream of n_out=23234 with err_det=1, err_uncorr=0. With ANDEC_ERRPOS_EN, err_pos=1,3,4,5,6,7,8,9,10 and residue=27,21,13,26,23,17,5,10,20.
- High-bit errors:
  - an_in=657402 -> residue 1, bit 14.
  - 542714 -> residue 8, bit 17.
  - 149498 -> residue 3, bit 19.
  - Each gives n_out=23234, err_det=1.
- Non-HL error: an_in=673787, a 0->1 flip of bit 0. R=1 maps to bit 14, but an_in[14]=1 -> err_det=1, err_uncorr=1.
- Reset mid-stream: assert rst_n=0 with two words in flight -> out_valid drops immediately and outputs read 0; after release, the clean word 673786 returns 23234 after 2 cycles.

Source files
------------

// File: rtl/an_decoder_hl.sv
// AN-code (A=29) decoder correcting one high-to-low bit error; optional err_pos/residue ports under ANDEC_ERRPOS_EN.
// Latency: 2 cycles, one word per cycle. Backpressure: none, out_valid is in_valid delayed by 2.
// Outputs hold their last values between valid words.
module an_decoder_hl #(
    parameter int A    = 29,
    parameter int CW_W = 28,
    parameter int N_W  = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [CW_W-1:0] an_in,
    output logic            out_valid,
    output logic [N_W-1:0]  n_out,
    output logic            err_det,
    output logic            err_uncorr
`ifdef ANDEC_ERRPOS_EN
    ,
    output logic [4:0]      err_pos,
    output logic [4:0]      residue
`endif
);

    localparam int RW = $clog2(A);
    localparam int IW = $clog2(CW_W);
    localparam logic [RW:0]     A_EXT = (RW+1)'(A);
    localparam logic [CW_W-1:0] CMAX  = CW_W'(longint'(A) * ((longint'(1) << N_W) - 1));

    // Serial shift-and-subtract reduction; the constant modulus keeps each step a compare/subtract.
    function automatic logic [RW-1:0] mod_a(input logic [CW_W-1:0] x);
        logic [RW:0] r;
        r = '0;
        for (int k = CW_W - 1; k >= 0; k--) begin
            r = {r[RW-1:0], x[k]};
            if (r >= A_EXT) r = r - A_EXT;
        end
        return r[RW-1:0];
    endfunction

    // (-2^i) mod A: the residue a lost 1 at bit i leaves behind.
    function automatic logic [RW-1:0] neg_pow2(input int i);
        int p;
        p = 1 % A;
        for (int k = 0; k < i; k++) begin
            p = 2 * p;
            if (p >= A) p -= A;
        end
        return RW'((A - p) % A);
    endfunction

    // Newton iteration for A^-1 mod 2^N_W, doubling correct bits each pass.
    function automatic logic [N_W-1:0] inv_a();
        logic [N_W-1:0] a, x;
        a = N_W'(A);
        x = a;
        for (int k = 0; k < 6; k++) x = x * (N_W'(2) - a * x);
        return x;
    endfunction

    localparam logic [N_W-1:0] AINV = inv_a();

    logic            s1_vld;
    logic [CW_W-1:0] s1_an;
    logic [RW-1:0]   s1_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_an  <= '0;
            s1_res <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_an  <= an_in;
                s1_res <= mod_a(an_in);
            end
        end
    end

    logic [IW-1:0]   idx;
    logic [CW_W-1:0] c_word;
    logic            det;
    logic            unc;
    logic [N_W-1:0]  quot;

    always_comb begin
        idx    = '0;
        c_word = s1_an;
        det    = (s1_res != '0);
        unc    = 1'b0;
        quot   = '0;
        if (det) begin
            for (int i = 0; i < CW_W; i++) begin
                if (s1_res == neg_pow2(i)) idx = IW'(i);
            end
            // A set bit at the flagged position means the error was not a lost 1.
            if (s1_an[idx]) unc = 1'b1;
            else            c_word = s1_an | (CW_W'(1) << idx);
        end
        if (c_word > CMAX) unc = 1'b1;
        // Exact division: only the low N_W bits of C affect the low N_W quotient bits.
        quot = c_word[N_W-1:0] * AINV;
    end

    logic [IW-1:0] pos_q;
    logic [RW-1:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            n_out      <= '0;
            err_det    <= 1'b0;
            err_uncorr <= 1'b0;
            pos_q      <= '0;
            res_q      <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                n_out      <= quot;
                err_det    <= det;
                err_uncorr <= unc;
                pos_q      <= idx;
                res_q      <= s1_res;
            end
        end
    end

`ifdef ANDEC_ERRPOS_EN
    assign err_pos = 5'(pos_q);
    assign residue = 5'(res_q);
`else
    logic unused_dbg;
    assign unused_dbg = ^{pos_q, res_q};
`endif

endmodule

// File: tb/tb_an_decoder_hl.sv
// Scoreboard bench for an_decoder_hl: expected results are queued at drive time and compared on output.
module tb_an_decoder_hl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [27:0] an_in;
    logic        out_valid;
    logic [22:0] n_out;
    logic        err_det;
    logic        err_uncorr;
`ifdef ANDEC_ERRPOS_EN
    logic [4:0]  err_pos;
    logic [4:0]  residue;
`endif

    an_decoder_hl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .an_in      (an_in),
        .out_valid  (out_valid),
        .n_out      (n_out),
        .err_det    (err_det),
        .err_uncorr (err_uncorr)
`ifdef ANDEC_ERRPOS_EN
        ,
        .err_pos    (err_pos),
        .residue    (residue)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int  n;
        bit  nchk;
        bit  det;
        bit  unc;
        int  res;
        int  pos;
        int  due;
    } exp_t;

    exp_t sbq[$];

    // Reference model: plain % and / arithmetic, with a search for the flipped bit.
    function automatic exp_t model(input int x);
        exp_t e;
        int c;
        int r;
        r     = x % 29;
        c     = x;
        e.res = r;
        e.det = (r != 0);
        e.pos = 0;
        e.unc = 0;
        if (r != 0) begin
            for (int i = 0; i < 28; i++)
                if ((((1 << i) % 29) + r) % 29 == 0) e.pos = i;
            if (((x >> e.pos) & 1) == 1) e.unc = 1;
            else                         c = x | (1 << e.pos);
        end
        if (c > 29 * 8388607) e.unc = 1;
        e.nchk = (c % 29 == 0);
        e.n    = (c / 29) & 32'h7F_FFFF;
        e.due  = 0;
        return e;
    endfunction

    // Caller is 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic send(input int x);
        exp_t e;
        e     = model(x);
        e.due = cyc + 2;
        sbq.push_back(e);
        in_valid = 1'b1;
        an_in    = 28'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("latency", cyc, e.due);
                    chk("err_det", err_det, e.det);
                    chk("err_uncorr", err_uncorr, e.unc);
                    if (e.nchk) chk("n_out", n_out, e.n);
`ifdef ANDEC_ERRPOS_EN
                    chk("err_pos", err_pos, e.det ? e.pos : 0);
                    chk("residue", residue, e.res);
`endif
                end
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
                chk("timeout", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    int sweep [9] = '{673784, 673778, 673770, 673754, 673722, 673658, 673530, 673274, 672762};
    int hibit [3] = '{657402, 542714, 149498};

    initial begin
        int nv;
        int x;
        int b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        an_in    = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_err_det", err_det, 0);
        chk("rst_err_uncorr", err_uncorr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(673786);
        repeat (3) @(posedge clk);
        #1;
        foreach (sweep[i]) send(sweep[i]);
        foreach (hibit[i]) send(hibit[i]);
        send(673787);
        send(29 * 8388607);
        send(29 * 8388608);
        send(268435455);
        send(0);
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 60; k++) begin
            nv = int'($urandom_range(0, 8388607));
            x  = 29 * nv;
            b  = int'($urandom_range(0, 27));
            if ($urandom_range(0, 3) != 0 && ((x >> b) & 1) == 1) x = x & ~(1 << b);
            if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 268435455));
            send(x);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;

        send(673786);
        send(673784);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_n_out", n_out, 0);
        chk("midrst_err_det", err_det, 0);
        chk("midrst_err_uncorr", err_uncorr, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(673786);

        repeat (6) @(posedge clk);
        #1;
        chk("drain_left", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
